// File: rtl/track_scroller_pkg.sv
// Shared constants for the scrolling level: state codes, line/landing heights, screen geometry.
package track_scroller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DEAD = 2'b10
  } state_t;

  localparam logic [8:0] LINE_Y0 = 9'd120;
  localparam logic [8:0] LINE_Y1 = 9'd240;
  localparam logic [8:0] LINE_Y2 = 9'd360;

  // Player top-left y when standing on a line: 60 px above it falling down, on it falling up.
  localparam logic [8:0] LAND_DN_L1 = 9'd180;
  localparam logic [8:0] LAND_DN_L2 = 9'd300;
  localparam logic [8:0] LAND_UP_L0 = 9'd120;
  localparam logic [8:0] LAND_UP_L1 = 9'd240;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COL_W    = 40;

  localparam logic [9:0] SCORE_MAX = 10'd1023;

endpackage

// File: rtl/track_scroller_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting left; seed load wins over enable.
// One-cycle update latency, no backpressure: advances on every en.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        load,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= SEED;
    else if (load)
      q <= SEED;
    else if (en)
      q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/track_scroller.sv
// Scrolling three-line ground map, gravity-flip and death FSM for the player-motion block.
// Outputs registered except lines (combinational from the map); no backpressure, presses are edges.
module track_scroller
  import track_scroller_pkg::*;
#(
  parameter int          N_COL      = 16,
  parameter int          PLAYER_COL = 2,
  parameter int          STEP_DIV   = 2_500_000,
  parameter int          DEATH_BOT  = 420,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_btn,
  input  logic             flip_btn,
  input  logic [8:0]       height,
  output logic [2:0]       lines,
  output logic             grav_dir,
  output logic             is_dead,
  output logic [N_COL-1:0] map_l0,
  output logic [N_COL-1:0] map_l1,
  output logic [N_COL-1:0] map_l2,
  output logic [9:0]       score,
  output logic [1:0]       state
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  state_t             st;
  logic               start_q, flip_q;
  logic [DIV_W-1:0]   div;
  logic [15:0]        lfsr_q;
  logic               start_p, flip_p, step, dead_now, grounded, run_go, shift;
  logic [2:0]         new_col;

  assign start_p  = start_btn & ~start_q;
  assign flip_p   = flip_btn & ~flip_q;
  assign step     = (div == DIV_W'(STEP_DIV - 1));
  assign dead_now = (height == 9'd0) || (height >= 9'(DEATH_BOT));
  assign run_go   = (st == ST_IDLE) && start_p;
  assign shift    = (st == ST_RUN) && !dead_now && step;
  assign lines    = {map_l2[PLAYER_COL], map_l1[PLAYER_COL], map_l0[PLAYER_COL]};
  assign state    = st;

  assign grounded = (!grav_dir && ((height == LAND_DN_L1 && lines[1]) ||
                                   (height == LAND_DN_L2 && lines[2]))) ||
                    ( grav_dir && ((height == LAND_UP_L0 && lines[0]) ||
                                   (height == LAND_UP_L1 && lines[1])));

  // An empty column would be an unwinnable gap, so it becomes middle-line ground.
  assign new_col = (lfsr_q[2:0] == 3'b000) ? 3'b010 : lfsr_q[2:0];

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (shift),
    .load  (run_go),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q <= 1'b0;
      flip_q  <= 1'b0;
    end else begin
      start_q <= start_btn;
      flip_q  <= flip_btn;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= ST_IDLE;
      grav_dir <= 1'b0;
      is_dead  <= 1'b1;
      score    <= '0;
      div      <= '0;
      map_l0   <= '0;
      map_l1   <= '1;
      map_l2   <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start_p) begin
            st       <= ST_RUN;
            is_dead  <= 1'b0;
            grav_dir <= 1'b0;
            score    <= '0;
            div      <= '0;
            map_l0   <= '0;
            map_l1   <= '1;
            map_l2   <= '0;
          end
        end
        ST_RUN: begin
          // Death freezes everything else in the same cycle.
          if (dead_now) begin
            st      <= ST_DEAD;
            is_dead <= 1'b1;
          end else begin
            if (flip_p && grounded)
              grav_dir <= ~grav_dir;
            if (step) begin
              div    <= '0;
              map_l0 <= {new_col[0], map_l0[N_COL-1:1]};
              map_l1 <= {new_col[1], map_l1[N_COL-1:1]};
              map_l2 <= {new_col[2], map_l2[N_COL-1:1]};
              if (score != SCORE_MAX)
                score <= score + 10'd1;
            end else begin
              div <= div + DIV_W'(1);
            end
          end
        end
        ST_DEAD: ;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_track_scroller.sv
// Randomized/directed bench for track_scroller against an array-based reference model.
module tb_track_scroller;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0;
  logic        flip_btn = 1'b0;
  logic [8:0]  height = 9'd200;
  logic [2:0]  lines;
  logic        grav_dir, is_dead;
  logic [15:0] map_l0, map_l1, map_l2;
  logic [9:0]  score;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  track_scroller #(.STEP_DIV(SD)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .flip_btn(flip_btn),
    .height(height), .lines(lines), .grav_dir(grav_dir), .is_dead(is_dead),
    .map_l0(map_l0), .map_l1(map_l1), .map_l2(map_l2), .score(score), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: line maps as bit arrays, run time counted in clocks.
  int          m_st, m_grav, m_score, m_cnt;
  logic [15:0] m_lfsr;
  bit          ml[3][16];
  bit          p_start, p_flip, m_shifted;

  function automatic logic [15:0] mvec(int k);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = ml[k][i];
    return v;
  endfunction

  function automatic logic [2:0] mlines();
    return {ml[2][2], ml[1][2], ml[0][2]};
  endfunction

  task automatic m_runway();
    for (int i = 0; i < 16; i++) begin
      ml[0][i] = 0; ml[1][i] = 1; ml[2][i] = 0;
    end
  endtask

  task automatic m_reset();
    m_st = 0; m_grav = 0; m_score = 0; m_cnt = 0;
    m_lfsr = 16'hACE1; p_start = 0; p_flip = 0;
    m_runway();
  endtask

  task automatic m_step();
    bit sp, fp, gnd;
    int h, c, fb;
    logic [2:0] ln;
    sp = start_btn && !p_start;
    fp = flip_btn && !p_flip;
    p_start = start_btn; p_flip = flip_btn;
    h = height; ln = mlines(); m_shifted = 0;
    if (m_st == 0) begin
      if (sp) begin
        m_st = 1; m_grav = 0; m_score = 0; m_cnt = 0; m_lfsr = 16'hACE1; m_runway();
      end
    end else if (m_st == 1) begin
      if (h == 0 || h >= 420) m_st = 2;
      else begin
        if (m_grav == 0) gnd = (h == 180 && ln[1]) || (h == 300 && ln[2]);
        else             gnd = (h == 120 && ln[0]) || (h == 240 && ln[1]);
        if (fp && gnd) m_grav = 1 - m_grav;
        m_cnt++;
        if (m_cnt == SD) begin
          m_cnt = 0; m_shifted = 1;
          c = m_lfsr % 8;
          if (c == 0) c = 2;
          for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 15; i++) ml[k][i] = ml[k][i+1];
            ml[k][15] = (c >> k) & 1;
          end
          if (m_score < 1023) m_score++;
          fb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
          m_lfsr = 16'(({16'd0, m_lfsr} << 1) | fb);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(state), 32'(m_st));
    chk({tag, ".is_dead"}, 32'(is_dead), (m_st == 1) ? 0 : 1);
    chk({tag, ".grav"}, 32'(grav_dir), 32'(m_grav));
    chk({tag, ".lines"}, 32'(lines), 32'(mlines()));
    chk({tag, ".map0"}, 32'(map_l0), 32'(mvec(0)));
    chk({tag, ".map1"}, 32'(map_l1), 32'(mvec(1)));
    chk({tag, ".map2"}, 32'(map_l2), 32'(mvec(2)));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
  endtask

  task automatic tick(input string tag);
    m_step();
    @(posedge clk); #1;
    check_all(tag);
    if (m_shifted)
      chk({tag, ".newcol_nz"}, 32'({map_l2[15], map_l1[15], map_l0[15]} != 3'b000), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".state"}, 32'(state), 0);
    chk({tag, ".is_dead"}, 32'(is_dead), 1);
    chk({tag, ".lines"}, 32'(lines), 32'h2);
    chk({tag, ".grav"}, 32'(grav_dir), 0);
    chk({tag, ".map1"}, 32'(map_l1), 32'hFFFF);
    chk({tag, ".map0"}, 32'(map_l0), 0);
    chk({tag, ".map2"}, 32'(map_l2), 0);
    chk({tag, ".score"}, 32'(score), 0);
  endtask

  // Reset is asserted between edges and checked before the next edge.
  task automatic do_reset(input string tag);
    start_btn = 0; flip_btn = 0;
    @(posedge clk); #1 reset = 1'b0;
    #2 check_reset_vals(tag);
    m_reset();
    @(posedge clk); #1 reset = 1'b1;
  endtask

  task automatic press_start();
    start_btn = 1; tick("start");
    start_btn = 0; tick("start_rel");
  endtask

  initial begin
    logic [15:0] s0, s1, s2;
    logic [9:0]  ssc;
    int          sg, hh;
    bit          found;

    m_reset();
    repeat (2) @(posedge clk);
    do_reset("reset");
    repeat (3) tick("idle");

    // Run 1: 64 clocks at step divider 4 -> 16 shifts, random airborne heights.
    height = 9'd200;
    start_btn = 1; tick("run1_go");
    start_btn = 0;
    for (int i = 0; i < 64; i++) begin
      hh = $urandom_range(1, 419);
      if (hh == 180 || hh == 300 || hh == 120 || hh == 240) hh = 200;
      height = 9'(hh);
      flip_btn = 1'($urandom_range(0, 1));
      tick("run1");
    end
    flip_btn = 0;
    chk("run1.state", 32'(state), 1);
    chk("run1.score16", 32'(score), 16);

    // Run 2: gravity flips on the runway.
    do_reset("reset2");
    height = 9'd200;
    start_btn = 1; tick("run2_go");
    start_btn = 0;
    flip_btn = 1; tick("flip_air"); flip_btn = 0; tick("flip_air_rel");
    chk("flip_airborne", 32'(grav_dir), 0);
    height = 9'd180;
    flip_btn = 1; tick("flip_gnd"); flip_btn = 0; tick("flip_gnd_rel");
    chk("flip_grounded", 32'(grav_dir), 1);
    // Hold flip while alternating heights that are grounded for either gravity.
    flip_btn = 1;
    for (int i = 0; i < 10; i++) begin
      height = (i % 2 == 0) ? 9'd240 : 9'd180;
      tick("flip_hold");
    end
    flip_btn = 0; height = 9'd200; tick("flip_hold_rel");
    chk("flip_hold_once", 32'(grav_dir), 0);

    // Death with a scroll due in the same cycle.
    found = 0;
    for (int i = 0; i < 2 * SD && !found; i++) begin
      if (m_cnt == SD - 1) found = 1;
      else tick("to_scroll");
    end
    chk("scroll_due_found", 32'(found), 1);
    s0 = mvec(0); s1 = mvec(1); s2 = mvec(2); ssc = 10'(m_score); sg = m_grav;
    height = 9'd420; tick("death");
    chk("death.state", 32'(state), 2);
    chk("death.is_dead", 32'(is_dead), 1);
    chk("death.map0", 32'(map_l0), 32'(s0));
    chk("death.map1", 32'(map_l1), 32'(s1));
    chk("death.map2", 32'(map_l2), 32'(s2));
    chk("death.score", 32'(score), 32'(ssc));
    height = 9'd180;
    press_start();
    flip_btn = 1; tick("dead_flip"); flip_btn = 0;
    repeat (6) tick("dead_hold");
    chk("dead.state_hold", 32'(state), 2);
    chk("dead.grav_hold", 32'(grav_dir), 32'(sg));
    chk("dead.score_hold", 32'(score), 32'(ssc));

    // Run 3: 1100 shifts saturates the score.
    do_reset("reset3");
    height = 9'd200;
    start_btn = 1; tick("run3_go");
    start_btn = 0;
    for (int i = 0; i < 1100 * SD; i++) begin
      height = ($urandom_range(0, 3) == 0) ? 9'd180 : 9'd200;
      flip_btn = 1'($urandom_range(0, 1));
      tick("run3");
    end
    flip_btn = 0; height = 9'd200;
    chk("score_sat", 32'(score), 1023);
    chk("run3.state", 32'(state), 1);

    // Asynchronous reset mid-run.
    do_reset("midrun_reset");
    repeat (2) tick("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/track_scroller.md
Name: track_scroller

Overview:
- Level-side partner of the player-motion block: it produces the `lines`, `grav_dir` and `is_dead` signals that the player-motion block consumes, and takes that block's `height` output back as an input.
- Keeps a scrolling map of ground segments on the three horizontal lines (y=120, 240, 360) and reports which lines exist at the player's column.
- Accepts gravity-flip requests and detects death when the player leaves the screen.
- Sits between the button/debounce logic and the player-motion and VGA drawing blocks.

Parameters:
- N_COL, 16, number of 40-px map columns across the 640-px screen.
- PLAYER_COL, 2, map column under the player's bottom-left corner.
- STEP_DIV, 2_500_000, clocks per one-column scroll step (minimum 2).
- DEATH_BOT, 420, height at or above which the player has fallen off the bottom.
- LFSR_SEED, 16'hACE1, reset/start seed of the pattern LFSR (must be non-zero).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start_btn  in  1  level from debouncer; its rising edge starts a run.
- flip_btn  in  1  level from debouncer; its rising edge requests a gravity flip.
- height  in  9  player top-left y, driven by the player-motion block.
- lines  out  3  ground present at PLAYER_COL: bit0 = y120, bit1 = y240, bit2 = y360.
- grav_dir  out  1  0 = gravity down, 1 = gravity up.
- is_dead  out  1  1 freezes the player; high in IDLE and DEAD.
- map_l0, map_l1, map_l2  out  N_COL each  full line maps for the VGA renderer; bit i = column i.
- score  out  10  columns scrolled this run, saturating at 1023.
- state  out  2  00 IDLE, 01 RUN, 10 DEAD.

Behaviour:
- Reset (reset=0, asynchronous), all outputs and registers:
  - state=IDLE, grav_dir=0, is_dead=1, score=0.
  - map_l1 = all ones; map_l0 = map_l2 = 0; LFSR = LFSR_SEED.
  - Divider = 0; both edge-detect registers = 0.
- Edge detect: the previous value of each button is registered every clock. A press is `btn & ~btn_q`, one cycle wide. A held button never repeats.
- IDLE:
  - is_dead=1, map frozen.
  - start press → RUN on the next edge.
  - Entering RUN reloads the runway map and LFSR seed, zeroes the divider and score, and sets grav_dir=0.
- RUN, scrolling:
  - is_dead=0. The divider counts 0..STEP_DIV-1.
  - On the cycle the divider equals STEP_DIV-1, every map shifts one column toward index 0.
  - Column N_COL-1 loads LFSR bits [2:0], mapped to l0, l1, l2. If those bits are 000, the column is forced to 010.
  - The LFSR advances once per shift, polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifting left.
  - score increments per shift, saturating at 1023.
- RUN, grounded: grounded = (grav_dir=0 & ((height==180 & lines[1]) | (height==300 & lines[2]))) | (grav_dir=1 & ((height==120 & lines[0]) | (height==240 & lines[1]))).
- RUN, gravity flip: a flip press while grounded toggles grav_dir on that edge. A flip press while airborne is dropped, not queued.
- RUN, death: height==0 or height>=DEATH_BOT → DEAD on the next edge. Death takes priority over a flip or a scroll in the same cycle: the map does not shift and grav_dir does not change.
- lines = {map_l2[PLAYER_COL], map_l1[PLAYER_COL], map_l0[PLAYER_COL]}. This is combinational from the map registers, so it updates in the same cycle as a shift.
- DEAD:
  - is_dead=1; map, score and grav_dir hold.
  - Button presses are ignored. Exit is by reset only, because the player block re-centres only on reset.
- Reset asserted mid-run: immediate return to the reset values above, no wait for the clock.

Decomposition:
- Shared package holds:
  - the state encodings;
  - the line y constants 120/240/360;
  - the landing heights 180/300 (gravity down) and 120/240 (gravity up);
  - screen size 640x480;
  - the 40-px column width.
- One sub-module, `lfsr16` (clk, reset, en, seed-load, q[15:0]), because the pattern generator is reusable by future obstacle blocks.
- The edge detect, divider and FSM stay inline.

Test Plan:
- Reset, no input → state=00, is_dead=1, lines=010, grav_dir=0, map_l1=16'hFFFF, score=0.
- STEP_DIV=4, start pulse, run 64 clocks → state=01, is_dead=0, exactly 16 shifts, score=16; no new column equals 000; map_l1[0] shifts at clocks 4, 8, … after entering RUN.
- RUN with height=180 and lines[1]=1, flip pulse → grav_dir=1 after one edge. Repeat with height=200 → grav_dir stays 0. Hold flip_btn high 10 clocks while grounded → exactly one toggle.
- Drive height=420 in RUN with a scroll due the same cycle → state=10, is_dead=1, map and score unchanged. Then start and flip pulses → no change.
- Force 1100 shifts → score saturates at 1023.
- Assert reset mid-RUN between clock edges → all outputs take their reset values before the next clk edge.
